// File: rtl/matrix_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : matrix_bram_arbiter
// Brief    : Round-robin arbiter sharing one single-port matrix BRAM among up
//            to four mode controllers, with tagged one-cycle read return.
//            Optional grant locking for bursts: define MATRIX_ARB_LOCK_EN.
// Revision : 1.0
// ============================================================================
module matrix_bram_arbiter #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 9,
  parameter int NUM_REQ       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*ELEMENT_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]               req_lock,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [ELEMENT_WIDTH-1:0]         rsp_rdata,
  output logic                             bram_en,
  output logic                             bram_we,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  output logic [ELEMENT_WIDTH-1:0]         bram_wdata,
  input  logic [ELEMENT_WIDTH-1:0]         bram_rdata,
  output logic                             busy
);

  localparam logic [2:0] c_num_req  = 3'(NUM_REQ);
  localparam logic [1:0] c_last_req = 2'(NUM_REQ - 1);

  logic [1:0]               r_rr_ptr;
  logic                     r_bram_en;
  logic                     r_bram_we;
  logic [ADDR_WIDTH-1:0]    r_bram_addr;
  logic [ELEMENT_WIDTH-1:0] r_bram_wdata;
  logic [1:0]               r_s1_tag;
  logic                     r_s2_valid;
  logic [1:0]               r_s2_tag;

  logic [3:0]               w_valid4;
  logic [3:0]               w_lock4;
  logic [3:0]               w_grant4;
  logic [3:0]               w_rsp4;
  logic [2:0]               w_idx;
  logic                     w_found;
  logic [1:0]               w_gidx;
  logic [1:0]               w_gidx_next;
  logic                     w_accept;
  logic                     w_sel_we;
  logic [ADDR_WIDTH-1:0]    w_sel_addr;
  logic [ELEMENT_WIDTH-1:0] w_sel_wdata;
  logic                     w_sel_lock;
  logic                     w_lock_active;
  logic [1:0]               w_lock_owner;
  logic [1:0]               w_owner_next;
  logic                     w_lock_release;

  // Pad request vectors to four lanes; unused lanes stay zero and never win.
  always_comb begin
    w_valid4                = '0;
    w_lock4                 = '0;
    w_valid4[NUM_REQ-1:0]   = req_valid;
    w_lock4[NUM_REQ-1:0]    = req_lock;
  end

  always_comb begin
    w_grant4 = '0;
    w_gidx   = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    if (!rst) begin
      if (w_lock_active) begin
        if (w_valid4[w_lock_owner]) begin
          w_grant4[w_lock_owner] = 1'b1;
          w_gidx                 = w_lock_owner;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          w_idx = {1'b0, r_rr_ptr} + 3'(k);
          if (w_idx >= c_num_req) w_idx = w_idx - c_num_req;
          if (!w_found && w_valid4[w_idx[1:0]]) begin
            w_found              = 1'b1;
            w_grant4[w_idx[1:0]] = 1'b1;
            w_gidx               = w_idx[1:0];
          end
        end
      end
    end
  end

  assign w_accept     = |w_grant4;
  assign req_ready    = w_grant4[NUM_REQ-1:0];
  assign w_gidx_next  = (w_gidx == c_last_req) ? 2'd0 : w_gidx + 2'd1;
  assign w_owner_next = (w_lock_owner == c_last_req) ? 2'd0 : w_lock_owner + 2'd1;

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_lock  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant4[i]) begin
        w_sel_we    = req_we[i];
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        w_sel_lock  = w_lock4[i];
      end
    end
  end

`ifdef MATRIX_ARB_LOCK_EN
  logic       r_lock_active;
  logic [1:0] r_lock_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_active <= 1'b0;
      r_lock_owner  <= '0;
    end else if (r_lock_active) begin
      if (!w_lock4[r_lock_owner]) r_lock_active <= 1'b0;
    end else if (w_accept && w_sel_lock) begin
      r_lock_active <= 1'b1;
      r_lock_owner  <= w_gidx;
    end
  end

  assign w_lock_active  = r_lock_active;
  assign w_lock_owner   = r_lock_owner;
  assign w_lock_release = r_lock_active & ~w_lock4[r_lock_owner];
`else
  logic w_unused_lock;

  assign w_lock_active  = 1'b0;
  assign w_lock_owner   = '0;
  assign w_lock_release = 1'b0;
  assign w_unused_lock  = ^{w_lock4, w_sel_lock};
`endif

  // Pointer is frozen during a lock and resumes just past the lock owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_lock_release) begin
      r_rr_ptr <= w_owner_next;
    end else if (w_accept && !w_lock_active) begin
      r_rr_ptr <= w_gidx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bram_en    <= 1'b0;
      r_bram_we    <= 1'b0;
      r_bram_addr  <= '0;
      r_bram_wdata <= '0;
      r_s1_tag     <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_tag     <= '0;
    end else begin
      r_bram_en  <= w_accept;
      r_bram_we  <= w_accept & w_sel_we;
      if (w_accept) begin
        r_bram_addr  <= w_sel_addr;
        r_bram_wdata <= w_sel_wdata;
        r_s1_tag     <= w_gidx;
      end
      r_s2_valid <= r_bram_en & ~r_bram_we;
      r_s2_tag   <= r_s1_tag;
    end
  end

  // Strobes are masked by rst so an in-flight beat never reaches the BRAM
  // or a requester while reset is held.
  always_comb begin
    w_rsp4 = '0;
    if (r_s2_valid && !rst) w_rsp4[r_s2_tag] = 1'b1;
  end

  assign rsp_valid  = w_rsp4[NUM_REQ-1:0];
  assign rsp_rdata  = bram_rdata;
  assign bram_en    = r_bram_en & ~rst;
  assign bram_we    = r_bram_we & ~rst;
  assign bram_addr  = r_bram_addr;
  assign bram_wdata = r_bram_wdata;
  assign busy       = bram_en | (r_s2_valid & ~rst);

endmodule
`default_nettype wire

// File: tb/tb_matrix_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_bram_arbiter
// Brief    : Directed self-checking bench for matrix_bram_arbiter.
// Revision : 1.0
// ============================================================================
module tb_matrix_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_we, req_lock;
  logic [35:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        bram_en, bram_we, busy;
  logic [8:0]  bram_addr;
  logic [7:0]  bram_wdata;
  logic [7:0]  bram_rdata;
  logic [7:0]  mem [0:511];

  int n_cmp  = 0;
  int n_fail = 0;

  matrix_bram_arbiter #(.ELEMENT_WIDTH(8), .ADDR_WIDTH(9), .NUM_REQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_lock(req_lock),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port BRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata     <= mem[bram_addr];
    end
  end

  task automatic clear_reqs();
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [8:0] a,
                         input logic [7:0] d, input logic lk);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_lock[i]  = lk;
    req_addr[i*9 +: 9]  = a;
    req_wdata[i*8 +: 8] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 9'(i), 8'hEE, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    n_cmp++; if (bram_en !== 1'b0 || bram_we !== 1'b0) begin n_fail++; $display("FAIL reset_bram_en_we: got %b%b want 00", bram_en, bram_we); end
    n_cmp++; if (bram_addr !== 9'h000 || bram_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_bram_addr_wdata: got %h/%h want 000/00", bram_addr, bram_wdata); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata_follow: got %h want 00", rsp_rdata); end
    clear_reqs();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    set_req(1, 1'b0, 9'h005, 8'h00, 1'b0);
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b want 0010", req_ready); end
    @(negedge clk);
    n_cmp++; if (bram_en !== 1'b1 || bram_we !== 1'b0 || bram_addr !== 9'h005) begin n_fail++; $display("FAIL single_issue: got en=%b we=%b addr=%h want 1/0/005", bram_en, bram_we, bram_addr); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    clear_reqs();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 8'h07) begin n_fail++; $display("FAIL single_rsp: got %b/%h want 0010/07", rsp_valid, rsp_rdata); end
    n_cmp++; if (bram_en !== 1'b0) begin n_fail++; $display("FAIL single_en_pulse: got %b want 0", bram_en); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b/%b want 0000/0", rsp_valid, busy); end
  endtask

  task automatic test_contention();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 9'h100 + 9'(i), 8'hA0 + 8'(i), 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1;
      n_cmp++; if (req_ready !== 4'(1 << exp_g[n])) begin n_fail++; $display("FAIL contention_grant%0d: got %b want req%0d", n, req_ready, exp_g[n]); end
      if (n > 0) begin
        n_cmp++;
        if (bram_en !== 1'b1 || bram_we !== 1'b1 || bram_addr !== 9'h100 + 9'(exp_g[n-1]) || bram_wdata !== 8'hA0 + 8'(exp_g[n-1])) begin
          n_fail++; $display("FAIL contention_issue%0d: got en=%b we=%b addr=%h d=%h want req%0d", n, bram_en, bram_we, bram_addr, bram_wdata, exp_g[n-1]);
        end
      end
      @(negedge clk);
    end
    n_cmp++; if (bram_en !== 1'b1 || bram_addr !== 9'h100 || bram_wdata !== 8'hA0) begin n_fail++; $display("FAIL contention_last: got en=%b addr=%h d=%h want 1/100/a0", bram_en, bram_addr, bram_wdata); end
    clear_reqs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_interleaved();
    set_req(0, 1'b0, 9'h010, 8'h00, 1'b0);
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL inter_ready0: got %b want 0001", req_ready); end
    @(negedge clk);
    clear_reqs();
    set_req(2, 1'b0, 9'h011, 8'h00, 1'b0);
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL inter_ready2: got %b want 0100", req_ready); end
    n_cmp++; if (bram_en !== 1'b1 || bram_addr !== 9'h010) begin n_fail++; $display("FAIL inter_issue0: got %b/%h want 1/010", bram_en, bram_addr); end
    @(negedge clk);
    clear_reqs();
    n_cmp++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 8'h03) begin n_fail++; $display("FAIL inter_rsp0: got %b/%h want 0001/03", rsp_valid, rsp_rdata); end
    n_cmp++; if (bram_en !== 1'b1 || bram_addr !== 9'h011) begin n_fail++; $display("FAIL inter_issue2: got %b/%h want 1/011", bram_en, bram_addr); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 8'h09) begin n_fail++; $display("FAIL inter_rsp2: got %b/%h want 0100/09", rsp_valid, rsp_rdata); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL inter_idle: got %b want 0000", rsp_valid); end
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    set_req(3, 1'b1, 9'h1F0, 8'h05, 1'b0);
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wr_ready: got %b want 1000", req_ready); end
    @(negedge clk);
    set_req(3, 1'b0, 9'h1F0, 8'h00, 1'b0);
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rd_ready: got %b want 1000", req_ready); end
    n_cmp++; if (bram_en !== 1'b1 || bram_we !== 1'b1 || bram_addr !== 9'h1F0 || bram_wdata !== 8'h05) begin n_fail++; $display("FAIL wr_issue: got en=%b we=%b addr=%h d=%h want 1/1/1f0/05", bram_en, bram_we, bram_addr, bram_wdata); end
    @(negedge clk);
    clear_reqs();
    n_cmp++; if (bram_en !== 1'b1 || bram_we !== 1'b0 || bram_addr !== 9'h1F0) begin n_fail++; $display("FAIL rd_issue: got en=%b we=%b addr=%h want 1/0/1f0", bram_en, bram_we, bram_addr); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL wr_no_rsp: got %b want 0000", rsp_valid); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 4'b1000 || rsp_rdata !== 8'h05) begin n_fail++; $display("FAIL wr_rd_rsp: got %b/%h want 1000/05", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_lock();
`ifdef MATRIX_ARB_LOCK_EN
    logic [3:0] exp_r [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001};
`else
    logic [3:0] exp_r [8] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0001, 4'b0001};
`endif
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      clear_reqs();
      if (k < 6)  set_req(2, 1'b1, 9'h080 + 9'(k), 8'(k), 1'b1);
      if (k >= 1) set_req(0, 1'b0, 9'h005, 8'h00, 1'b0);
      #1;
      n_cmp++; if (req_ready !== exp_r[k]) begin n_fail++; $display("FAIL lock_cycle%0d: got %b want %b", k, req_ready, exp_r[k]); end
    end
    @(negedge clk);
    clear_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    set_req(1, 1'b0, 9'h005, 8'h00, 1'b0);
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL midrst_ready: got %b want 0010", req_ready); end
    @(negedge clk);
    clear_reqs();
    rst = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_rsp_during: got %b want 0000", rsp_valid); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_busy: got %b/%b want 0000/0", rsp_valid, busy); end
    n_cmp++; if (bram_en !== 1'b0 || bram_we !== 1'b0 || bram_addr !== 9'h000 || bram_wdata !== 8'h00) begin n_fail++; $display("FAIL midrst_bram: got en=%b we=%b addr=%h d=%h want 0/0/000/00", bram_en, bram_we, bram_addr, bram_wdata); end
    rst = 1'b0;
    set_req(0, 1'b0, 9'h005, 8'h00, 1'b0);
    set_req(1, 1'b0, 9'h005, 8'h00, 1'b0);
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_rr_reset: got %b want 0001", req_ready); end
    @(negedge clk);
    clear_reqs();
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_no_late_rsp: got %b want 0000", rsp_valid); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 8'h00;
    mem[9'h005] = 8'h07;
    mem[9'h010] = 8'h03;
    mem[9'h011] = 8'h09;
    bram_rdata = 8'h00;
    clear_reqs();
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_contention();
    test_interleaved();
    test_write_then_read();
    test_lock();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
